pool_psum_reader: RTL

Read-side initiator for the psum global buffer's pool port. Walks a configured address range and pulls one NUM_PEB-lane psum word per address. Max-reduces groups of consecutive addresses per lane, then requantizes to ACT_WIDTH and streams the results to the activation writer. Sits between the psum GB and the output activation path, and signals patch completion back to the GB.

---
 rtl/pool_pkg.sv | 26 ++
 rtl/pool_lane.sv | 55 +++++
 rtl/pool_psum_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the psum pool reader.
// Optional build macro POOL_RELU_EN (see pool_lane.sv).
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int POOL_LEN_MAX = 4;
    localparam int SHIFT_W      = 5;

    // Clamp a wide signed value into [lo, hi].
    function automatic longint sat_signed(input longint v, input longint lo, input longint hi);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One psum lane: max-accumulator, arithmetic shift, optional ReLU, saturation.
// Build macro POOL_RELU_EN: when defined, negative results clamp to zero.
module pool_lane
    import pool_pkg::*;
#(
    parameter int PSUM_WIDTH = 32,
    parameter int ACT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         first,
    input  logic                         close,
    input  logic [SHIFT_W-1:0]           shift,
    input  logic signed [PSUM_WIDTH-1:0] data,
    output logic signed [ACT_WIDTH-1:0]  act
);

    localparam longint ACT_HI = (longint'(1) <<< (ACT_WIDTH - 1)) - 1;
`ifdef POOL_RELU_EN
    localparam longint ACT_LO = 0;
`else
    localparam longint ACT_LO = -ACT_HI - 1;
`endif

    logic signed [PSUM_WIDTH-1:0] acc_reg;
    logic signed [PSUM_WIDTH-1:0] acc_next;
    logic signed [PSUM_WIDTH-1:0] shifted;
    logic signed [ACT_WIDTH-1:0]  act_reg;
    logic signed [ACT_WIDTH-1:0]  act_next;

    // Next accumulator value and the requantized result of that value.
    always_comb begin
        acc_next = first ? data : ((data > acc_reg) ? data : acc_reg);
        shifted  = acc_next >>> shift;
        act_next = ACT_WIDTH'(sat_signed(longint'(shifted), ACT_LO, ACT_HI));
    end

    // Accumulate on each transfer; capture the output when the group closes
    // so the pooled value is registered and valid in the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
            act_reg <= '0;
        end else if (load) begin
            acc_reg <= acc_next;
            if (close) begin
                act_reg <= act_next;
            end
        end
    end

    assign act = act_reg;

endmodule

// File: rtl/pool_psum_reader.sv
// Pool-port read initiator: walks a GB address range, max-pools groups of
// consecutive words per lane, requantizes and streams results downstream.
// Build macro POOL_RELU_EN enables ReLU clamping in every lane.
module pool_psum_reader
    import pool_pkg::*;
#(
    parameter int NUM_PEB    = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ACT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          CFGPOOL_val,
    output logic                          POOLCFG_rdy,
    input  logic [ADDR_WIDTH:0]           CFGPOOL_num_addr,
    input  logic [2:0]                    CFGPOOL_pool_len,
    input  logic [4:0]                    CFGPOOL_shift,
    output logic [ADDR_WIDTH-1:0]         POOLGB_addr,
    output logic                          POOLGB_rdy,
    input  logic                          GBPOOL_val,
    input  logic [PSUM_WIDTH*NUM_PEB-1:0] GBPOOL_data,
    output logic                          POOLGB_fnh,
    output logic                          POOLOUT_val,
    input  logic                          OUTPOOL_rdy,
    output logic [ACT_WIDTH*NUM_PEB-1:0]  POOLOUT_data
);

    localparam logic [ADDR_WIDTH:0] ADDR_ONE = 1;
    localparam logic [2:0]          LEN_MAX  = 3'(POOL_LEN_MAX);

    state_t                 state_reg;
    state_t                 state_next;
    logic [ADDR_WIDTH:0]    num_addr_reg;
    logic [2:0]             pool_len_reg;
    logic [SHIFT_W-1:0]     shift_reg;
    logic [ADDR_WIDTH:0]    addr_reg;
    logic [2:0]             grp_reg;
    logic [2:0]             pool_len_cfg;
    logic                   cfg_fire;
    logic                   xfer;
    logic                   first;
    logic                   close;
    logic                   more;

    assign pool_len_cfg = (CFGPOOL_pool_len == 3'd0) ? 3'd1 :
                          (CFGPOOL_pool_len > LEN_MAX) ? LEN_MAX : CFGPOOL_pool_len;
    assign cfg_fire     = (state_reg == IDLE) && CFGPOOL_val;
    assign xfer         = (state_reg == READ) && GBPOOL_val;
    assign first        = (grp_reg == 3'd0);
    // Group closes on reaching pool_len or on the last address of the patch.
    assign close        = xfer && (((grp_reg + 3'd1) == pool_len_reg) ||
                                   ((addr_reg + ADDR_ONE) == num_addr_reg));
    assign more         = (addr_reg != num_addr_reg);
    assign POOLGB_addr  = addr_reg[ADDR_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        POOLCFG_rdy = 1'b0;
        POOLGB_rdy  = 1'b0;
        POOLOUT_val = 1'b0;
        POOLGB_fnh  = 1'b0;
        case (state_reg)
            IDLE: begin
                POOLCFG_rdy = 1'b1;
                if (CFGPOOL_val) begin
                    state_next = (CFGPOOL_num_addr == '0) ? DONE : READ;
                end
            end
            READ: begin
                POOLGB_rdy = 1'b1;
                if (close) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                POOLOUT_val = 1'b1;
                if (OUTPOOL_rdy) begin
                    state_next = more ? READ : DONE;
                end
            end
            DONE: begin
                POOLGB_fnh = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Configuration latch plus address and group counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_addr_reg <= '0;
            pool_len_reg <= 3'd1;
            shift_reg    <= '0;
            addr_reg     <= '0;
            grp_reg      <= '0;
        end else if (cfg_fire) begin
            num_addr_reg <= CFGPOOL_num_addr;
            pool_len_reg <= pool_len_cfg;
            shift_reg    <= CFGPOOL_shift;
            addr_reg     <= '0;
            grp_reg      <= '0;
        end else if (xfer) begin
            addr_reg <= addr_reg + ADDR_ONE;
            grp_reg  <= close ? 3'd0 : grp_reg + 3'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PEB; gi++) begin : g_lane
            pool_lane #(
                .PSUM_WIDTH (PSUM_WIDTH),
                .ACT_WIDTH  (ACT_WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (xfer),
                .first (first),
                .close (close),
                .shift (shift_reg),
                .data  (GBPOOL_data[gi*PSUM_WIDTH +: PSUM_WIDTH]),
                .act   (POOLOUT_data[gi*ACT_WIDTH +: ACT_WIDTH])
            );
        end
    endgenerate

endmodule
